bra_pre_sel_upd: RTL and testbench

//  Update-side controller for the branch-predictor selection (chooser) table.

---
 rtl/bra_pre_sel_upd.sv | 152 +++++++++++++++
 tb/tb_bra_pre_sel_upd.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bra_pre_sel_upd.sv
// Chooser-table update controller: buffers resolved-branch events, does saturating RMW, flush sweep.
// Latency: table write the cycle after accept at the earliest, +1 cycle per lookup-stall cycle.
// Backpressure: upd_ready low while flushing or FIFO full; lookups always win the table port.
module bra_pre_sel_upd #(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 2,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] INIT_VAL   = DATA_W'(2'b10)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [ADDR_W-1:0]           upd_idx,
  input  logic                        upd_loc_ok,
  input  logic                        upd_glb_ok,
  input  logic                        lkp_req,
  input  logic [ADDR_W-1:0]           lkp_idx,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic [ADDR_W-1:0]           tab_addr,
  output logic                        tab_wr_en,
  output logic [DATA_W-1:0]           tab_wr_data,
  input  logic [DATA_W-1:0]           tab_rd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [DATA_W-1:0] MAX_VAL  = '1;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_FLUSH} state_t;

  // One buffered event: which counter, and whether it moves toward global (inc) or local.
  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic              inc;
  } ent_t;

  state_t            state_q, state_d;
  ent_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              flush_done_q, flush_done_d;
  logic              push, pop, sweep_wr;
  logic [DATA_W-1:0] rmw_data;
  ent_t              head;

  assign head       = mem_q[rd_ptr_q];
  assign upd_ready  = (state_q != ST_FLUSH) && (cnt_q < CNT_W'(FIFO_DEPTH));
  // Events where both components agree carry no chooser information: accept and drop them.
  assign push       = upd_valid && upd_ready && (upd_loc_ok != upd_glb_ok);
  // Reset gates the write strobes so an in-flight update or sweep stops on the reset cycle.
  assign pop        = !reset && !lkp_req && (state_q == ST_UPDATE) && (cnt_q != '0);
  assign sweep_wr   = !reset && !lkp_req && (state_q == ST_FLUSH);
  assign fifo_cnt   = cnt_q;
  assign flush_done = flush_done_q;

  // Saturating step of the counter currently read at the head event's index.
  always_comb begin
    rmw_data = tab_rd_data;
    if (head.inc) begin
      if (tab_rd_data != MAX_VAL) rmw_data = tab_rd_data + 1'b1;
    end else begin
      if (tab_rd_data != '0) rmw_data = tab_rd_data - 1'b1;
    end
  end

  // Table port mux: lookup owns the port outright, otherwise sweep or head-of-queue RMW.
  always_comb begin
    tab_addr    = head.idx;
    tab_wr_data = rmw_data;
    tab_wr_en   = pop || sweep_wr;
    if (lkp_req) begin
      tab_addr = lkp_idx;
    end else if (state_q == ST_FLUSH) begin
      tab_addr = sweep_q;
    end
    if (state_q == ST_FLUSH) tab_wr_data = INIT_VAL;
  end

  // Next-state: FIFO pointers/count, sweep pointer and controller state.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    sweep_d      = sweep_q;
    flush_done_d = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    case (state_q)
      ST_IDLE, ST_UPDATE: begin
        if (flush_req) begin
          // Pending events are stale once the table is reinitialised: drop them.
          state_d  = ST_FLUSH;
          sweep_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
        end else if (cnt_d != '0) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (sweep_wr) begin
          sweep_d = sweep_q + 1'b1;
          if (sweep_q == LAST_IDX) begin
            flush_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      sweep_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      sweep_q      <= sweep_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Event storage; contents are only meaningful below cnt_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{idx: upd_idx, inc: upd_glb_ok};
  end

endmodule

// File: tb/tb_bra_pre_sel_upd.sv
module tb_bra_pre_sel_upd;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          upd_valid;
  logic          upd_ready;
  logic [AW-1:0] upd_idx;
  logic          upd_loc_ok;
  logic          upd_glb_ok;
  logic          lkp_req;
  logic [AW-1:0] lkp_idx;
  logic          flush_req;
  logic          flush_done;
  logic [AW-1:0] tab_addr;
  logic          tab_wr_en;
  logic [1:0]    tab_wr_data;
  logic [1:0]    tab_rd_data;
  logic [2:0]    fifo_cnt;

  // Table model: either a forced read value or an 8-entry array written by the DUT.
  logic          use_model;
  logic [1:0]    rd_force;
  logic [1:0]    tbl [0:7];
  logic          model_clr;
  logic          preset_en;
  logic [AW-1:0] preset_idx;
  logic [1:0]    preset_val;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign tab_rd_data = use_model ? tbl[tab_addr] : rd_force;

  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 8; i++) tbl[i] <= 2'd0;
    end else if (preset_en) begin
      tbl[preset_idx] <= preset_val;
    end else if (tab_wr_en) begin
      tbl[tab_addr] <= tab_wr_data;
    end
  end

  bra_pre_sel_upd #(.ADDR_W(AW), .DATA_W(2), .FIFO_DEPTH(4), .INIT_VAL(2'b10)) dut (
    .clk(clk), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
    .upd_loc_ok(upd_loc_ok), .upd_glb_ok(upd_glb_ok),
    .lkp_req(lkp_req), .lkp_idx(lkp_idx),
    .flush_req(flush_req), .flush_done(flush_done),
    .tab_addr(tab_addr), .tab_wr_en(tab_wr_en), .tab_wr_data(tab_wr_data),
    .tab_rd_data(tab_rd_data), .fifo_cnt(fifo_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] idx, input logic loc, input logic glb);
    upd_valid  = 1'b1;
    upd_idx    = idx;
    upd_loc_ok = loc;
    upd_glb_ok = glb;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (fifo_cnt !== 3'd0) $display("FAIL rst_cnt: got %0d want 0", fifo_cnt); else passes++;
    checks++; if (flush_done !== 1'b0) $display("FAIL rst_done: got %0b want 0", flush_done); else passes++;
    checks++; if (tab_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %0b want 0", tab_wr_en); else passes++;
    checks++; if (upd_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", upd_ready); else passes++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    use_model = 1'b0;
    rd_force  = 2'd1;
    offer(3'd5, 1'b0, 1'b1);
    #1;
    checks++; if (upd_ready !== 1'b1) $display("FAIL basic_ready: got %0b want 1", upd_ready); else passes++;
    tick();
    upd_valid = 1'b0;
    #1;
    checks++; if (tab_addr !== 3'd5) $display("FAIL basic_addr: got %0d want 5", tab_addr); else passes++;
    checks++; if (tab_wr_en !== 1'b1) $display("FAIL basic_wr_en: got %0b want 1", tab_wr_en); else passes++;
    checks++; if (tab_wr_data !== 2'd2) $display("FAIL basic_data: got %0d want 2", tab_wr_data); else passes++;
    checks++; if (fifo_cnt !== 3'd1) $display("FAIL basic_cnt: got %0d want 1", fifo_cnt); else passes++;
    tick();
    checks++; if (fifo_cnt !== 3'd0) $display("FAIL basic_cnt_after: got %0d want 0", fifo_cnt); else passes++;
    checks++; if (tab_wr_en !== 1'b0) $display("FAIL basic_wr_en_after: got %0b want 0", tab_wr_en); else passes++;
  endtask

  task automatic test_saturate();
    rd_force = 2'd3;
    offer(3'd1, 1'b0, 1'b1);
    tick();
    upd_valid = 1'b0;
    #1;
    checks++; if (tab_wr_en !== 1'b1) $display("FAIL sat_hi_wr_en: got %0b want 1", tab_wr_en); else passes++;
    checks++; if (tab_wr_data !== 2'd3) $display("FAIL sat_hi_data: got %0d want 3", tab_wr_data); else passes++;
    tick();
    rd_force = 2'd0;
    offer(3'd2, 1'b1, 1'b0);
    tick();
    upd_valid = 1'b0;
    #1;
    checks++; if (tab_addr !== 3'd2) $display("FAIL sat_lo_addr: got %0d want 2", tab_addr); else passes++;
    checks++; if (tab_wr_en !== 1'b1) $display("FAIL sat_lo_wr_en: got %0b want 1", tab_wr_en); else passes++;
    checks++; if (tab_wr_data !== 2'd0) $display("FAIL sat_lo_data: got %0d want 0", tab_wr_data); else passes++;
    tick();
  endtask

  task automatic test_filter();
    for (int k = 0; k < 2; k++) begin
      offer(3'd3, k[0] == 1'b0, k[0] == 1'b0);
      #1;
      checks++; if (upd_ready !== 1'b1) $display("FAIL filt_ready%0d: got %0b want 1", k, upd_ready); else passes++;
      tick();
      upd_valid = 1'b0;
      #1;
      checks++; if (fifo_cnt !== 3'd0) $display("FAIL filt_cnt%0d: got %0d want 0", k, fifo_cnt); else passes++;
      checks++; if (tab_wr_en !== 1'b0) $display("FAIL filt_wr_en%0d: got %0b want 0", k, tab_wr_en); else passes++;
    end
    tick();
    checks++; if (tab_wr_en !== 1'b0) $display("FAIL filt_wr_en_late: got %0b want 0", tab_wr_en); else passes++;
  endtask

  task automatic test_lkp_stall();
    rd_force = 2'd1;
    lkp_req  = 1'b1;
    lkp_idx  = 3'd6;
    for (int i = 0; i < 5; i++) begin
      offer(AW'(i + 1), 1'b0, 1'b1);
      #1;
      checks++; if (upd_ready !== (i < 4)) $display("FAIL stall_ready%0d: got %0b want %0b", i, upd_ready, i < 4); else passes++;
      checks++; if (tab_wr_en !== 1'b0) $display("FAIL stall_wr_en%0d: got %0b want 0", i, tab_wr_en); else passes++;
      checks++; if (tab_addr !== 3'd6) $display("FAIL stall_addr%0d: got %0d want 6", i, tab_addr); else passes++;
      tick();
    end
    upd_valid = 1'b0;
    #1;
    checks++; if (fifo_cnt !== 3'd4) $display("FAIL stall_cnt: got %0d want 4", fifo_cnt); else passes++;
    checks++; if (tab_wr_en !== 1'b0) $display("FAIL stall_wr_en5: got %0b want 0", tab_wr_en); else passes++;
    tick();
    lkp_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (tab_wr_en !== 1'b1) $display("FAIL drain_wr_en%0d: got %0b want 1", i, tab_wr_en); else passes++;
      checks++; if (tab_addr !== AW'(i + 1)) $display("FAIL drain_addr%0d: got %0d want %0d", i, tab_addr, i + 1); else passes++;
      checks++; if (tab_wr_data !== 2'd2) $display("FAIL drain_data%0d: got %0d want 2", i, tab_wr_data); else passes++;
      tick();
    end
    checks++; if (fifo_cnt !== 3'd0) $display("FAIL drain_cnt: got %0d want 0", fifo_cnt); else passes++;
    checks++; if (tab_wr_en !== 1'b0) $display("FAIL drain_idle: got %0b want 0", tab_wr_en); else passes++;
  endtask

  task automatic test_back_to_back();
    use_model  = 1'b1;
    preset_en  = 1'b1;
    preset_idx = 3'd7;
    preset_val = 2'd1;
    tick();
    preset_en = 1'b0;
    offer(3'd7, 1'b0, 1'b1);
    tick();
    offer(3'd7, 1'b0, 1'b1);
    #1;
    checks++; if (tab_addr !== 3'd7) $display("FAIL b2b_addr0: got %0d want 7", tab_addr); else passes++;
    checks++; if (tab_wr_en !== 1'b1) $display("FAIL b2b_wr_en0: got %0b want 1", tab_wr_en); else passes++;
    checks++; if (tab_wr_data !== 2'd2) $display("FAIL b2b_data0: got %0d want 2", tab_wr_data); else passes++;
    tick();
    upd_valid = 1'b0;
    #1;
    checks++; if (fifo_cnt !== 3'd1) $display("FAIL b2b_cnt: got %0d want 1", fifo_cnt); else passes++;
    checks++; if (tab_wr_en !== 1'b1) $display("FAIL b2b_wr_en1: got %0b want 1", tab_wr_en); else passes++;
    checks++; if (tab_wr_data !== 2'd3) $display("FAIL b2b_data1: got %0d want 3", tab_wr_data); else passes++;
    tick();
    checks++; if (tbl[7] !== 2'd3) $display("FAIL b2b_table: got %0d want 3", tbl[7]); else passes++;
  endtask

  task automatic test_flush();
    use_model = 1'b1;
    model_clr = 1'b1;
    tick();
    model_clr = 1'b0;
    lkp_req   = 1'b1;
    lkp_idx   = 3'd4;
    offer(3'd1, 1'b0, 1'b1);
    tick();
    offer(3'd2, 1'b0, 1'b1);
    tick();
    upd_valid = 1'b0;
    checks++; if (fifo_cnt !== 3'd2) $display("FAIL fl_queued: got %0d want 2", fifo_cnt); else passes++;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    lkp_req   = 1'b0;
    #1;
    checks++; if (fifo_cnt !== 3'd0) $display("FAIL fl_cleared: got %0d want 0", fifo_cnt); else passes++;
    checks++; if (upd_ready !== 1'b0) $display("FAIL fl_ready: got %0b want 0", upd_ready); else passes++;
    for (int p = 0; p < 8; p++) begin
      if (p == 3) begin
        lkp_req   = 1'b1;
        lkp_idx   = 3'd5;
        flush_req = 1'b1;
        #1;
        checks++; if (tab_wr_en !== 1'b0) $display("FAIL fl_stall_wr_en: got %0b want 0", tab_wr_en); else passes++;
        checks++; if (tab_addr !== 3'd5) $display("FAIL fl_stall_addr: got %0d want 5", tab_addr); else passes++;
        tick();
        lkp_req   = 1'b0;
        flush_req = 1'b0;
      end
      #1;
      checks++; if (tab_addr !== AW'(p)) $display("FAIL fl_addr%0d: got %0d want %0d", p, tab_addr, p); else passes++;
      checks++; if (tab_wr_en !== 1'b1) $display("FAIL fl_wr_en%0d: got %0b want 1", p, tab_wr_en); else passes++;
      checks++; if (tab_wr_data !== 2'b10) $display("FAIL fl_data%0d: got %0d want 2", p, tab_wr_data); else passes++;
      checks++; if (flush_done !== 1'b0) $display("FAIL fl_early_done%0d: got %0b want 0", p, flush_done); else passes++;
      tick();
    end
    checks++; if (flush_done !== 1'b1) $display("FAIL fl_done: got %0b want 1", flush_done); else passes++;
    checks++; if (tab_wr_en !== 1'b0) $display("FAIL fl_end_wr_en: got %0b want 0", tab_wr_en); else passes++;
    tick();
    checks++; if (flush_done !== 1'b0) $display("FAIL fl_done_pulse: got %0b want 0", flush_done); else passes++;
    checks++; if (upd_ready !== 1'b1) $display("FAIL fl_ready_after: got %0b want 1", upd_ready); else passes++;
    checks++; if (tab_wr_en !== 1'b0) $display("FAIL fl_no_stale_wr: got %0b want 0", tab_wr_en); else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tbl[i] !== 2'b10) $display("FAIL fl_table%0d: got %0d want 2", i, tbl[i]); else passes++;
    end
  endtask

  task automatic test_flush_reset();
    model_clr = 1'b1;
    tick();
    model_clr = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1;
    checks++; if (tab_wr_en !== 1'b1 || tab_addr !== 3'd0) $display("FAIL flr_wr0: got en=%0b addr=%0d want en=1 addr=0", tab_wr_en, tab_addr); else passes++;
    tick();
    checks++; if (tab_wr_en !== 1'b1 || tab_addr !== 3'd1) $display("FAIL flr_wr1: got en=%0b addr=%0d want en=1 addr=1", tab_wr_en, tab_addr); else passes++;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (tab_wr_en !== 1'b0) $display("FAIL flr_abort: got %0b want 0", tab_wr_en); else passes++;
    tick();
    checks++; if (upd_ready !== 1'b1) $display("FAIL flr_ready: got %0b want 1", upd_ready); else passes++;
    checks++; if (flush_done !== 1'b0) $display("FAIL flr_done: got %0b want 0", flush_done); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (tab_wr_en !== 1'b0) $display("FAIL flr_idle: got %0b want 0", tab_wr_en); else passes++;
    tick();
    tick();
    checks++; if (tbl[0] !== 2'b10) $display("FAIL flr_tbl0: got %0d want 2", tbl[0]); else passes++;
    checks++; if (tbl[1] !== 2'b10) $display("FAIL flr_tbl1: got %0d want 2", tbl[1]); else passes++;
    checks++; if (tbl[2] !== 2'd0) $display("FAIL flr_tbl2: got %0d want 0", tbl[2]); else passes++;
    checks++; if (flush_done !== 1'b0) $display("FAIL flr_no_done: got %0b want 0", flush_done); else passes++;
  endtask

  initial begin
    reset      = 1'b1;
    upd_valid  = 1'b0;
    upd_idx    = '0;
    upd_loc_ok = 1'b0;
    upd_glb_ok = 1'b0;
    lkp_req    = 1'b0;
    lkp_idx    = '0;
    flush_req  = 1'b0;
    use_model  = 1'b0;
    rd_force   = 2'd0;
    model_clr  = 1'b1;
    preset_en  = 1'b0;
    preset_idx = '0;
    preset_val = 2'd0;
    tick();
    model_clr = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_filter();
    test_lkp_stall();
    test_back_to_back();
    test_flush();
    test_flush_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
